// File: rtl/inject_scheduler.sv
// Host-side flit injector: steers flits into per-node 2-entry FIFOs and emits them toward the NoC splitter.
// A small IDLE/RUN/DRAIN/DONE controller gates injection, and a saturating counter tracks discarded flits.
module inject_scheduler #(
  parameter int DATA_W       = 8,
  parameter int NODE_PER_ROW = 4,
  parameter int NODE_PER_COL = 4,
  localparam int N    = NODE_PER_ROW * NODE_PER_COL,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                drain_req,
  output logic                drain_done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ID_W-1:0]     in_dest,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [N-1:0]        stall_i,
  input  logic                cfg_we,
  input  logic [N-1:0]        cfg_off_mask,
  output logic [N-1:0]        valid_o,
  output logic [DATA_W*N-1:0] data_o,
  output logic [N-1:0]        off_sigs_o,
  output logic [15:0]         drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0]   mem_q [N][2];
  logic [1:0]          cnt_q [N];
  logic [1:0]          cnt_d [N];
  logic                rd_q  [N];
  logic                rd_d  [N];
  logic                wr_q  [N];
  logic                wr_d  [N];

  logic [N-1:0]        off_mask_q, off_mask_d;
  logic [N-1:0]        off_sigs_q;
  logic [N-1:0]        valid_q, valid_d;
  logic [DATA_W*N-1:0] data_q, data_d;
  logic [15:0]         drop_q, drop_d;

  logic                active;
  logic                all_empty;
  logic [ID_W:0]       dest_ext;
  logic                dest_in_range;
  logic                dest_off;
  logic                dest_full;
  logic                accept;
  logic                discard_in;
  logic [N-1:0]        push_vec, pop_vec, flush_vec;
  logic [16:0]         drop_inc, drop_sum;

  // Destinations beyond the node count are legal and simply discarded.
  assign dest_ext      = {1'b0, in_dest};
  assign dest_in_range = dest_ext < (ID_W+1)'(N);
  assign dest_off      = dest_in_range && off_mask_q[in_dest];
  assign dest_full     = dest_in_range && (cnt_q[in_dest] == 2'd2);
  assign accept        = in_valid && in_ready;
  assign discard_in    = accept && (!dest_in_range || dest_off);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    // NOTE: default assignment first keeps every path assigned, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)     state_d = S_RUN;
      S_RUN:   if (drain_req) state_d = S_DRAIN;
      S_DRAIN: if (all_empty) state_d = S_DONE;
      S_DONE:  if (start)     state_d = S_RUN;
      default:                state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready   = (state_q == S_RUN) && (!dest_in_range || dest_off || !dest_full);
    drain_done = (state_q == S_DONE);
    active     = (state_q == S_RUN) || (state_q == S_DRAIN);
  end

  // Per-node push / pop / flush decisions; a pop never frees room for a same-cycle push.
  always_comb begin
    all_empty = 1'b1;
    push_vec  = '0;
    pop_vec   = '0;
    flush_vec = '0;
    for (int n = 0; n < N; n++) begin
      push_vec[n]  = accept && dest_in_range && !dest_off && (in_dest == ID_W'(n));
      pop_vec[n]   = active && (cnt_q[n] != 2'd0) && !stall_i[n] && !off_mask_q[n];
      flush_vec[n] = (state_q == S_DRAIN) && (cnt_q[n] != 2'd0) && off_mask_q[n];
      if (cnt_q[n] != 2'd0) all_empty = 1'b0;
    end
  end

  always_comb begin
    for (int n = 0; n < N; n++) begin
      cnt_d[n] = cnt_q[n] + 2'(push_vec[n]) - 2'(pop_vec[n] | flush_vec[n]);
      rd_d[n]  = rd_q[n] ^ (pop_vec[n] | flush_vec[n]);
      wr_d[n]  = wr_q[n] ^ push_vec[n];
    end
  end

  always_comb begin
    valid_d = pop_vec;
    data_d  = data_q;
    for (int n = 0; n < N; n++) begin
      if (pop_vec[n]) data_d[n*DATA_W +: DATA_W] = mem_q[n][rd_q[n]];
    end
  end

  // Saturating drop counter: input discards plus all flushes of this cycle.
  always_comb begin
    drop_inc = 17'(discard_in);
    for (int n = 0; n < N; n++) drop_inc = drop_inc + 17'(flush_vec[n]);
    drop_sum = {1'b0, drop_q} + drop_inc;
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  assign off_mask_d = cfg_we ? cfg_off_mask : off_mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < N; n++) begin
        cnt_q[n] <= 2'd0;
        rd_q[n]  <= 1'b0;
        wr_q[n]  <= 1'b0;
      end
      off_mask_q <= '0;
      off_sigs_q <= '0;
      valid_q    <= '0;
      data_q     <= '0;
      drop_q     <= '0;
    end else begin
      for (int n = 0; n < N; n++) begin
        cnt_q[n] <= cnt_d[n];
        rd_q[n]  <= rd_d[n];
        wr_q[n]  <= wr_d[n];
      end
      off_mask_q <= off_mask_d;
      off_sigs_q <= off_mask_q;
      valid_q    <= valid_d;
      data_q     <= data_d;
      drop_q     <= drop_d;
    end
  end

  // NOTE: FIFO storage is not reset; occupancy counters alone decide which entries are live.
  always_ff @(posedge clk) begin
    for (int n = 0; n < N; n++) begin
      if (push_vec[n]) mem_q[n][wr_q[n]] <= in_data;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign off_sigs_o = off_sigs_q;
  assign drop_cnt   = drop_q;

endmodule
